// File: rtl/cache_pkg.sv
// Shared types for the L1 data cache: FSM states and RISC-V load/store width codes.
package cache_pkg;

  typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_t;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  function automatic logic f3_load_ok(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic f3_store_ok(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
  endfunction

  // Unsupported codes report misaligned so they never touch a line.
  function automatic logic f3_aligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_B, F3_BU: return 1'b1;
      F3_H, F3_HU: return ~off[0];
      F3_W:        return off == 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Byte-lane select and sign/zero extension of a little-endian word for loads.
module load_extend
  import cache_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            func3,
  input  logic [1:0]            offset,
  input  logic [DATA_WIDTH-1:0] word,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic [DATA_WIDTH-1:0] shifted;

  assign shifted = word >> {offset, 3'b000};

  always_comb begin
    data_out = '0;
    case (func3)
      F3_B:  data_out = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
      F3_H:  data_out = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
      F3_W:  data_out = shifted;
      F3_BU: data_out = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
      F3_HU: data_out = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
      default: data_out = '0;
    endcase
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, one-word-line, write-through/no-allocate data cache in front of
// a combinational data memory. Load misses stall for exactly two cycles.
module data_cache
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int INDEX_BITS = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  read_enable,
  input  logic                  write_enable,
  input  logic [2:0]            func3,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  stall,
  input  logic                  flush,
  output logic                  mem_write_enable,
  output logic [2:0]            mem_func3,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_WIDTH - INDEX_BITS - 2;

  state_t state, state_next;

  logic [LINES-1:0]      valid_q;
  logic [TAG_W-1:0]      tag_q  [LINES];
  logic [DATA_WIDTH-1:0] data_q [LINES];

  logic [INDEX_BITS-1:0] index, end_index;
  logic [TAG_W-1:0]      tag;
  logic [1:0]            offset;
  logic                  aligned, tag_match, rd_req, wr_req;
  logic                  hit, load_miss, bypass, store_hit, store_split, crosses;
  logic [DATA_WIDTH-1:0] line_word, load_word, store_word;

  assign offset    = address[1:0];
  assign index     = address[INDEX_BITS+1:2];
  assign tag       = address[ADDR_WIDTH-1:INDEX_BITS+2];
  assign aligned   = f3_aligned(func3, offset);
  assign line_word = data_q[index];
  assign tag_match = valid_q[index] && (tag_q[index] == tag);

  assign rd_req      = (state == IDLE) && read_enable && !write_enable;
  assign wr_req      = (state == IDLE) && write_enable;
  assign hit         = rd_req && aligned && tag_match;
  assign load_miss   = rd_req && aligned && !tag_match;
  assign bypass      = rd_req && f3_load_ok(func3) && !aligned;
  assign store_hit   = wr_req && f3_store_ok(func3) && aligned && tag_match;
  assign store_split = wr_req && f3_store_ok(func3) && !aligned;

  // A misaligned word always spills into the next line; a halfword only from offset 3.
  assign crosses   = (func3 == F3_W) || (offset == 2'b11);
  assign end_index = index + INDEX_BITS'(crosses);

  load_extend #(.DATA_WIDTH(DATA_WIDTH)) u_load_extend (
    .func3    (func3),
    .offset   (offset),
    .word     (line_word),
    .data_out (load_word)
  );

  always_comb begin
    store_word = line_word;
    case (func3)
      F3_B: store_word[{offset, 3'b000} +: 8]  = write_data[7:0];
      F3_H: store_word[{offset, 3'b000} +: 16] = write_data[15:0];
      F3_W: store_word = write_data;
      default: store_word = line_word;
    endcase
  end

  always_comb begin
    state_next       = state;
    stall            = 1'b0;
    data_out         = '0;
    mem_write_enable = wr_req;
    mem_func3        = func3;
    mem_address      = address;
    mem_write_data   = write_data;
    case (state)
      IDLE: begin
        if (load_miss) begin
          stall      = 1'b1;
          state_next = FETCH;
        end
        if (hit)         data_out = load_word;
        else if (bypass) data_out = mem_data_out;
      end
      FETCH: begin
        stall            = 1'b1;
        mem_write_enable = 1'b0;
        mem_func3        = F3_W;
        mem_address      = {address[ADDR_WIDTH-1:2], 2'b00};
        state_next       = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      valid_q <= '0;
    end else begin
      state <= state_next;
      if (flush) begin
        valid_q <= '0;
      end else if (state == FETCH) begin
        valid_q[index] <= 1'b1;
      end else if (store_split) begin
        valid_q[index]     <= 1'b0;
        valid_q[end_index] <= 1'b0;
      end
    end
  end

  // Tag/data arrays carry no reset; valid_q alone decides whether they mean anything.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && state == FETCH) begin
      tag_q[index]  <= tag;
      data_q[index] <= mem_data_out;
    end else if (store_hit) begin
      data_q[index] <= store_word;
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Directed scoreboard bench for data_cache against a byte-addressed behavioural memory.
module tb_data_cache;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        read_enable, write_enable, flush;
  logic [2:0]  func3;
  logic [31:0] address, write_data, data_out;
  logic        stall;
  logic        mem_write_enable;
  logic [2:0]  mem_func3;
  logic [31:0] mem_address, mem_write_data, mem_data_out;

  logic [7:0]  mem [4096];
  logic        poke_en = 1'b0;
  logic [11:0] poke_a  = '0;
  logic [7:0]  poke_d  = '0;

  typedef struct {
    string       tag;
    logic        stall;
    logic        chk_data;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  int tests = 0;
  int fails = 0;

  data_cache dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .read_enable      (read_enable),
    .write_enable     (write_enable),
    .func3            (func3),
    .address          (address),
    .write_data       (write_data),
    .data_out         (data_out),
    .stall            (stall),
    .flush            (flush),
    .mem_write_enable (mem_write_enable),
    .mem_func3        (mem_func3),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_data_out     (mem_data_out)
  );

  always #5 clk = ~clk;

  // Behavioural data memory: combinational extended read, byte-granular write.
  logic [11:0] ma;
  logic [7:0]  b0, b1, b2, b3;
  always_comb begin
    ma = mem_address[11:0];
    b0 = mem[ma];
    b1 = mem[ma + 12'd1];
    b2 = mem[ma + 12'd2];
    b3 = mem[ma + 12'd3];
    case (mem_func3)
      3'd0:    mem_data_out = {{24{b0[7]}}, b0};
      3'd1:    mem_data_out = {{16{b1[7]}}, b1, b0};
      3'd2:    mem_data_out = {b3, b2, b1, b0};
      3'd4:    mem_data_out = {24'd0, b0};
      3'd5:    mem_data_out = {16'd0, b1, b0};
      default: mem_data_out = 32'd0;
    endcase
  end

  always @(posedge clk) begin
    if (poke_en) mem[poke_a] <= poke_d;
    if (mem_write_enable) begin
      case (mem_func3)
        3'd0: mem[ma] <= mem_write_data[7:0];
        3'd1: begin
          mem[ma]          <= mem_write_data[7:0];
          mem[ma + 12'd1]  <= mem_write_data[15:8];
        end
        3'd2: begin
          mem[ma]          <= mem_write_data[7:0];
          mem[ma + 12'd1]  <= mem_write_data[15:8];
          mem[ma + 12'd2]  <= mem_write_data[23:16];
          mem[ma + 12'd3]  <= mem_write_data[31:24];
        end
        default: ;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [11:0] a, input logic [7:0] d);
    poke_en = 1'b1; poke_a = a; poke_d = d;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  task automatic drive(input logic re, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic fl, input logic rs);
    read_enable = re; write_enable = we; func3 = f3;
    address = a; write_data = wd; flush = fl; rst_n = rs;
  endtask

  task automatic expect_out(input string tag, input logic es, input logic cd, input logic [31:0] ed);
    exp_t e;
    e.tag = tag; e.stall = es; e.chk_data = cd; e.data = ed;
    sb.push_back(e);
  endtask

  task automatic sample();
    exp_t e;
    @(negedge clk);
    if (sb.size() == 0) begin
      tests++; fails++;
      $error("FAIL scoreboard_empty: got 0 entries, expected 1");
    end else begin
      e = sb.pop_front();
      chk({e.tag, "_stall"}, {31'd0, stall}, {31'd0, e.stall});
      if (e.chk_data) chk({e.tag, "_data"}, data_out, e.data);
    end
  endtask

  task automatic advance();
    @(posedge clk); #1;
  endtask

  task automatic load_hit(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] exp);
    drive(1, 0, f3, a, 0, 0, 1);
    expect_out(tag, 1'b0, 1'b1, exp);
    sample();
    advance();
  endtask

  task automatic lw_miss(input string tag, input logic [31:0] a, input logic [31:0] exp);
    drive(1, 0, 3'd2, a, 0, 0, 1);
    expect_out({tag, "_miss"}, 1'b1, 1'b0, 0);
    sample();
    advance();
    expect_out({tag, "_fetch"}, 1'b1, 1'b0, 0);
    sample();
    chk({tag, "_fetch_addr"}, mem_address, {a[31:2], 2'b00});
    chk({tag, "_fetch_f3"}, {29'd0, mem_func3}, 32'd2);
    chk({tag, "_fetch_we"}, {31'd0, mem_write_enable}, 32'd0);
    advance();
    expect_out({tag, "_fill"}, 1'b0, 1'b1, exp);
    sample();
    advance();
  endtask

  task automatic store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic also_read);
    drive(also_read, 1, f3, a, wd, 0, 1);
    expect_out(tag, 1'b0, 1'b0, 0);
    sample();
    chk({tag, "_mem_we"}, {31'd0, mem_write_enable}, 32'd1);
    chk({tag, "_mem_addr"}, mem_address, a);
    chk({tag, "_mem_wd"}, mem_write_data, wd);
    chk({tag, "_mem_f3"}, {29'd0, mem_func3}, {29'd0, f3});
    advance();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(0, 0, 3'd0, 0, 0, 0, 0);
    // Memory preload doubles as the reset period.
    poke(12'h000, 8'hEF); poke(12'h001, 8'hBE); poke(12'h002, 8'hAD); poke(12'h003, 8'hDE);
    poke(12'h100, 8'h44); poke(12'h101, 8'h33); poke(12'h102, 8'h22); poke(12'h103, 8'h11);

    drive(0, 0, 3'd0, 0, 0, 0, 1);
    expect_out("reset_idle", 1'b0, 1'b1, 32'd0);
    sample();
    chk("reset_mem_we", {31'd0, mem_write_enable}, 32'd0);
    advance();

    lw_miss("lw_first", 32'h0001_0000, 32'hDEAD_BEEF);
    load_hit("lw_repeat_hit", 3'd2, 32'h0001_0000, 32'hDEAD_BEEF);

    store("sb", 3'd0, 32'h0001_0001, 32'h0000_007F, 1'b0);
    chk("sb_mem_byte", {24'd0, mem[12'h001]}, 32'h0000_007F);
    load_hit("lb_after_sb", 3'd0, 32'h0001_0001, 32'h0000_007F);
    load_hit("lbu_byte0", 3'd4, 32'h0001_0000, 32'h0000_00EF);
    load_hit("lw_after_sb", 3'd2, 32'h0001_0000, 32'hDEAD_7FEF);
    load_hit("lb_sign", 3'd0, 32'h0001_0003, 32'hFFFF_FFDE);
    load_hit("lhu_upper", 3'd5, 32'h0001_0002, 32'h0000_DEAD);
    load_hit("lh_upper", 3'd1, 32'h0001_0002, 32'hFFFF_DEAD);

    store("sh", 3'd1, 32'h0001_0002, 32'h0000_1234, 1'b0);
    load_hit("lw_after_sh", 3'd2, 32'h0001_0000, 32'h1234_7FEF);

    poke(12'h003, 8'h80); poke(12'h004, 8'h12);
    drive(1, 0, 3'd1, 32'h0001_0003, 0, 0, 1);
    expect_out("lh_misaligned", 1'b0, 1'b1, 32'h0000_1280);
    sample();
    chk("lh_misaligned_addr", mem_address, 32'h0001_0003);
    advance();
    // Cache must still hold its own copy, not the poked memory bytes.
    load_hit("lw_line_unchanged", 3'd2, 32'h0001_0000, 32'h1234_7FEF);

    store("sw_misaligned", 3'd2, 32'h0001_0002, 32'hAABB_CCDD, 1'b0);
    lw_miss("lw_after_split", 32'h0001_0000, 32'hCCDD_7FEF);

    lw_miss("lw_alias", 32'h0001_0100, 32'h1122_3344);
    lw_miss("lw_evicted", 32'h0001_0000, 32'hCCDD_7FEF);

    drive(1, 0, 3'd2, 32'h0001_0100, 0, 0, 1);
    expect_out("flush_miss", 1'b1, 1'b0, 0);
    sample(); advance();
    drive(1, 0, 3'd2, 32'h0001_0100, 0, 1, 1);
    expect_out("flush_fetch", 1'b1, 1'b0, 0);
    sample(); advance();
    drive(0, 0, 3'd0, 0, 0, 0, 1);
    expect_out("flush_idle", 1'b0, 1'b1, 32'd0);
    sample(); advance();
    lw_miss("lw_after_abort", 32'h0001_0100, 32'h1122_3344);

    drive(0, 0, 3'd0, 0, 0, 1, 1);
    expect_out("flush_plain", 1'b0, 1'b1, 32'd0);
    sample(); advance();
    lw_miss("lw_after_flush", 32'h0001_0100, 32'h1122_3344);

    drive(1, 0, 3'd2, 32'h0001_0000, 0, 0, 1);
    expect_out("rst_miss", 1'b1, 1'b0, 0);
    sample(); advance();
    drive(1, 0, 3'd2, 32'h0001_0000, 0, 0, 0);
    expect_out("rst_fetch", 1'b1, 1'b0, 0);
    sample(); advance();
    drive(0, 0, 3'd0, 0, 0, 0, 1);
    expect_out("rst_idle", 1'b0, 1'b1, 32'd0);
    sample();
    chk("rst_idle_mem_we", {31'd0, mem_write_enable}, 32'd0);
    advance();
    lw_miss("lw_after_rst", 32'h0001_0000, 32'hCCDD_7FEF);

    load_hit("load_unsupported", 3'd3, 32'h0001_0000, 32'd0);
    store("store_unsupported", 3'd7, 32'h0001_0000, 32'h0000_0055, 1'b0);
    load_hit("lw_after_unsup", 3'd2, 32'h0001_0000, 32'hCCDD_7FEF);

    store("sw_priority", 3'd2, 32'h0001_0000, 32'h0102_0304, 1'b1);
    load_hit("lw_after_prio", 3'd2, 32'h0001_0000, 32'h0102_0304);

    drive(0, 0, 3'd0, 0, 0, 0, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, CPU and memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width.
REQ-003 SHALL have parameter INDEX_BITS, default 6, log2 of line count (64 one-word lines).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have port read_enable  input  1  CPU load request.
REQ-007 SHALL have port write_enable  input  1  CPU store request; takes priority if both are high.
REQ-008 SHALL have port func3  input  3  RISC-V load/store width code (0 B, 1 H, 2 W, 4 BU, 5 HU).
REQ-009 SHALL have port address  input  ADDR_WIDTH  CPU byte address.
REQ-010 SHALL have port write_data  input  DATA_WIDTH  CPU store data.
REQ-011 SHALL have port data_out  output  DATA_WIDTH  extended load result.
REQ-012 SHALL have port stall  output  1  high while the CPU must hold its request stable.
REQ-013 SHALL have port flush  input  1  invalidate all lines.
REQ-014 SHALL have ports mem_write_enable, mem_func3, mem_address, mem_write_data  outputs  1/3/ADDR_WIDTH/DATA_WIDTH  data_memory request port.
REQ-015 SHALL have port mem_data_out  input  DATA_WIDTH  data_memory combinational read data.

Function
REQ-016 SHALL be direct-mapped: index = address[INDEX_BITS+1:2], tag = address[ADDR_WIDTH-1:INDEX_BITS+2], one valid bit per line.
REQ-017 Hit SHALL be defined as read_enable high, state IDLE, valid[index] set, tag matching, and access aligned.
REQ-018 An access SHALL be aligned when func3 is B/BU, H/HU with address[0]=0, or W with address[1:0]=0.
REQ-019 On a load hit, data_out SHALL be valid combinationally in the same cycle with stall low; B/H SHALL sign-extend and BU/HU SHALL zero-extend the selected bytes.
REQ-020 On an aligned load miss in IDLE, stall SHALL assert combinationally and the FSM SHALL move to FETCH.
REQ-021 In FETCH, the block SHALL drive mem_func3=2, mem_address={address[ADDR_WIDTH-1:2],2'b00}, and mem_write_enable=0, keep stall high, and at the clock edge write mem_data_out, the tag, and valid=1 into the line, then return to IDLE.
REQ-022 Load miss latency SHALL be exactly 2 cycles (miss cycle, FETCH cycle), with a hit on the third cycle.
REQ-023 A misaligned load SHALL bypass the cache: forward func3/address to memory, return mem_data_out directly, keep stall low, and leave the lines unchanged.
REQ-024 A store SHALL be write-through, no-allocate, and zero-stall: in the same cycle, mem_write_enable=1 with the CPU func3/address/write_data passed through.
REQ-025 A store that hits an aligned, valid, tag-matching line SHALL update only the addressed bytes of that line at the same edge.
REQ-026 A store that misses, or is misaligned, SHALL leave all lines unchanged, except that a misaligned store SHALL invalidate any valid line it touches.
REQ-027 In IDLE with no request, memory outputs SHALL pass through the CPU fields with mem_write_enable=0.
REQ-028 flush SHALL clear all valid bits at the next edge; flush in FETCH SHALL abort the fill (no line written) and return to IDLE.
REQ-029 Unsupported func3 values SHALL produce data_out=0 on loads and be passed through unchanged on stores.

Reset
REQ-030 While rst_n=0 at a clock edge, the state SHALL become IDLE and all valid bits SHALL clear; tag/data arrays need not reset.
REQ-031 After reset, stall SHALL be 0 with no request, mem_write_enable SHALL be 0, and data_out SHALL be 0 with no request.
REQ-032 Reset asserted during FETCH SHALL discard the fill.

Structure
REQ-033 The FSM state enum (IDLE, FETCH) and the func3 width codes SHALL live in a shared package, cache_pkg.
REQ-034 Byte-lane extraction/extension SHALL be one sub-module, load_extend (func3, byte offset, word -> data_out), which is also reusable by the memory stage.
REQ-035 Tag, data, and valid arrays SHALL be flop-based arrays inside data_cache.

Verification
REQ-036 Reset, then LW 0x00010000 (memory 0xDEADBEEF): stall high for 2 cycles, then data_out=0xDEADBEEF with stall low.
REQ-037 Repeat of the same LW SHALL hit: stall=0 and data_out=0xDEADBEEF in the same cycle, with no memory read in FETCH.
REQ-038 SB 0x00010001 data 0x7F after the fill, then LB 0x00010001: data_out=0x0000007F; then LBU 0x00010000: data_out=0x000000EF; memory byte also updated.
REQ-039 LH at 0x00010003 (misaligned) with memory bytes 0x80,0x12: data_out=0x00001280 via bypass with stall low.
REQ-040 Alias: LW 0x00010100 (same index, different tag) after 0x00010000 SHALL miss, refill, and evict; a following LW 0x00010000 misses again.
REQ-041 flush or rst_n=0 asserted during FETCH: next cycle IDLE, stall=0, and the next LW to the same address misses.
